// File: rtl/tdm_xor_demux_pkg.sv
// Shared definitions for the TDM XOR masking path (transmit masker and receive demux).
// Holds default link parameters, the framing FSM states and the keystream step.
package tdm_xor_demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 4;
  localparam logic [DEF_DATA_W-1:0] DEF_POLY = 8'hB8;
  localparam logic [DEF_DATA_W-1:0] DEF_LFSR_SEED = 8'hA5;

  // Widest keystream lfsr_next can serve; callers zero-extend and truncate.
  localparam int LFSR_MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Galois right-shift step: shift out the lsb and fold the polynomial back in.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] poly
  );
    lfsr_next = s >> 1;
    if (s[0]) lfsr_next = lfsr_next ^ poly;
  endfunction

endpackage

// File: rtl/xor_lfsr_keygen.sv
// Keystream generator: seed register with zero-seed filtering and a running LFSR
// that is reloaded from the seed at every frame start.
module xor_lfsr_keygen
  import tdm_xor_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] POLY = DEF_POLY,
  parameter logic [DATA_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_seed,
  input  logic              reload,
  input  logic              advance,
  output logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] lfsr
);

  logic [DATA_W-1:0] seed_step;
  logic [DATA_W-1:0] lfsr_step;

  assign seed_step = DATA_W'(lfsr_next(LFSR_MAX_W'(seed), LFSR_MAX_W'(POLY)));
  assign lfsr_step = DATA_W'(lfsr_next(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(POLY)));

  // A zero seed would lock the keystream at zero, so it is never accepted.
  // reload reads the pre-edge seed, so a key_load on an SOF word affects only later frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed <= LFSR_SEED;
      lfsr <= LFSR_SEED;
    end else begin
      if (key_load && (key_seed != '0)) seed <= key_seed;
      if (reload) lfsr <= seed_step;
      else if (advance) lfsr <= lfsr_step;
    end
  end

endmodule

// File: rtl/tdm_xor_demux.sv
// Receive-side TDM XOR demux: unmasks each slot with the regenerated keystream,
// tags it with its channel, and flags framing violations.
module tdm_xor_demux
  import tdm_xor_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter logic [DATA_W-1:0] POLY = DEF_POLY,
  parameter logic [DATA_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_seed,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done,
  output logic              sync_err,
  output logic              dbg_state
);

  // Handshake: no backpressure. Every cycle with in_valid high is consumed at that
  // clock edge (in_sof is ignored without in_valid); the result appears one cycle
  // later as a single-cycle out_valid pulse, with out_ch/out_data holding otherwise.

  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] SLOT_ONE  = (NUM_CH > 1) ? CH_W'(1) : '0;

  state_t            state, state_n;
  logic [CH_W-1:0]   slot, slot_n;
  logic              valid_n, done_n, err_n;
  logic [CH_W-1:0]   ch_n;
  logic [DATA_W-1:0] data_n;
  logic              reload, advance;
  logic [DATA_W-1:0] seed, lfsr;

  xor_lfsr_keygen #(
    .DATA_W    (DATA_W),
    .POLY      (POLY),
    .LFSR_SEED (LFSR_SEED)
  ) u_keygen (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_seed (key_seed),
    .reload   (reload),
    .advance  (advance),
    .seed     (seed),
    .lfsr     (lfsr)
  );

  assign dbg_state = (state == RUN);

  always_comb begin
    state_n = state;
    slot_n  = slot;
    valid_n = 1'b0;
    ch_n    = out_ch;
    data_n  = out_data;
    done_n  = 1'b0;
    err_n   = 1'b0;
    reload  = 1'b0;
    advance = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // SOF always restarts at slot 0 keyed by the seed; inside a frame it is also an error.
        valid_n = 1'b1;
        ch_n    = '0;
        data_n  = in_data ^ seed;
        reload  = 1'b1;
        err_n   = (state == RUN);
        if (NUM_CH == 1) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = RUN;
          slot_n  = SLOT_ONE;
        end
      end else if (state == IDLE) begin
        err_n = 1'b1;
      end else begin
        valid_n = 1'b1;
        ch_n    = slot;
        data_n  = in_data ^ lfsr;
        advance = 1'b1;
        if (slot == LAST_SLOT) begin
          done_n  = 1'b1;
          slot_n  = '0;
          state_n = IDLE;
        end else begin
          slot_n = slot + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      out_valid  <= valid_n;
      out_ch     <= ch_n;
      out_data   <= data_n;
      frame_done <= done_n;
      sync_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_tdm_xor_demux.sv
// Directed bench for tdm_xor_demux: keystream, unmasking, framing errors, seed
// handling, gaps and mid-frame reset, with hand-computed expected values.
module tb_tdm_xor_demux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       key_load = 1'b0;
  logic [7:0] key_seed = 8'h00;
  logic       out_valid;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic       frame_done;
  logic       sync_err;
  logic       dbg_state;

  int checks = 0;
  int errors = 0;

  // {valid, ch, data, frame_done, sync_err}
  logic [12:0] obs;
  assign obs = {out_valid, out_ch, out_data, frame_done, sync_err};

  tdm_xor_demux dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .key_load   (key_load),
    .key_seed   (key_seed),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // One clock: inputs set at negedge, outputs for that word observable #1 after posedge.
  task automatic drive(input logic v, input logic s, input logic [7:0] d,
                       input logic kl, input logic [7:0] ks);
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_sof = s; in_data = d; key_load = kl; key_seed = ks;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00; key_load = 1'b0; key_seed = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0);
    end
    checks++;
    if (dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0", dbg_state);
    end
  endtask

  task automatic test_keystream();
    logic [7:0]  exp_d [4];
    logic [12:0] exp;
    exp_d = '{8'hA5, 8'hEA, 8'h75, 8'h82};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 8'h00, 1'b0, 8'h00);
      exp = {1'b1, 2'(i), exp_d[i], i == 3, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL keystream slot %0d: got %h expected %h", i, obs, exp);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++;
    if ({out_valid, frame_done, dbg_state} !== 3'b000) begin
      errors++;
      $display("FAIL keystream_after: got %b expected 000", {out_valid, frame_done, dbg_state});
    end
  endtask

  task automatic test_unmask();
    logic [7:0]  in_d [4];
    logic [7:0]  exp_d [4];
    logic [12:0] exp;
    in_d  = '{8'hB4, 8'hF8, 8'h66, 8'hC6};
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h44};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 4) == 0, in_d[i % 4], 1'b0, 8'h00);
      exp = {1'b1, 2'(i % 4), exp_d[i % 4], (i % 4) == 3, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL unmask word %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_sync_idle();
    drive(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    checks++;
    if ({out_valid, frame_done, sync_err, dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL sof_without_valid: got %b expected 0000", {out_valid, frame_done, sync_err, dbg_state});
    end
    drive(1'b1, 1'b0, 8'h55, 1'b0, 8'h00);
    checks++;
    if ({out_valid, frame_done, sync_err, dbg_state} !== 4'b0010) begin
      errors++;
      $display("FAIL idle_no_sof: got %b expected 0010", {out_valid, frame_done, sync_err, dbg_state});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++;
    if ({out_valid, sync_err} !== 2'b00) begin
      errors++;
      $display("FAIL idle_err_pulse: got %b expected 00", {out_valid, sync_err});
    end
  endtask

  task automatic test_sync_run();
    logic        sof_v [6];
    logic [1:0]  exp_c [6];
    logic [7:0]  exp_d [6];
    logic [12:0] exp;
    sof_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_d = '{8'hA5, 8'hEA, 8'hA5, 8'hEA, 8'h75, 8'h82};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, sof_v[i], 8'h00, 1'b0, 8'h00);
      exp = {1'b1, exp_c[i], exp_d[i], i == 5, i == 2};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL premature_sof word %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  // key_load at word kl_idx; frame 1 keeps seed A5, frame 2 runs from 3C.
  task automatic seed_frames(input string name, input int kl_idx);
    logic [7:0]  exp_d [8];
    logic [12:0] exp;
    exp_d = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h3C, 8'h1E, 8'h0F, 8'hBF};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 4) == 0, 8'h00, i == kl_idx, 8'h3C);
      exp = {1'b1, 2'(i % 4), exp_d[i], (i % 4) == 3, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s word %0d: got %h expected %h", name, i, obs, exp);
      end
    end
  endtask

  task automatic test_seed_reload();
    seed_frames("seed_reload_midframe", 1);
  endtask

  task automatic test_load_on_sof();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
    seed_frames("seed_load_on_sof", 0);
  endtask

  task automatic test_zero_seed();
    logic [7:0]  exp_d [4];
    logic [12:0] exp;
    exp_d = '{8'hA5, 8'hEA, 8'h75, 8'h82};
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 8'h00, 1'b0, 8'h00);
      exp = {1'b1, 2'(i), exp_d[i], i == 3, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_seed slot %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0]  in_d [4];
    logic [7:0]  exp_d [4];
    logic [12:0] exp;
    in_d  = '{8'hB4, 8'hF8, 8'h66, 8'hC6};
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, in_d[i], 1'b0, 8'h00);
      exp = {1'b1, 2'(i), exp_d[i], i == 3, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL gaps slot %0d: got %h expected %h", i, obs, exp);
      end
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 1'b0, 8'hFF, 1'b0, 8'h00);
        checks++;
        if ({out_valid, frame_done, sync_err} !== 3'b000) begin
          errors++;
          $display("FAIL gaps idle %0d.%0d: got %b expected 000", i, g, {out_valid, frame_done, sync_err});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0]  exp_d [4];
    logic [12:0] exp;
    exp_d = '{8'hA5, 8'hEA, 8'h75, 8'h82};
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h3C);
    drive(1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    checks++;
    if (obs !== {1'b1, 2'd0, 8'h3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset slot0: got %h expected %h", obs, {1'b1, 2'd0, 8'h3C, 2'b00});
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    checks++;
    if (obs !== {1'b1, 2'd1, 8'h1E, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset slot1: got %h expected %h", obs, {1'b1, 2'd1, 8'h1E, 2'b00});
    end
    do_reset();
    checks++;
    if ({obs, dbg_state} !== 14'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected %h", {obs, dbg_state}, 14'h0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 8'h00, 1'b0, 8'h00);
      exp = {1'b1, 2'(i), exp_d[i], i == 3, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL after_reset slot %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_keystream();
    test_unmask();
    test_sync_idle();
    test_sync_run();
    test_seed_reload();
    test_load_on_sof();
    test_zero_seed();
    test_gaps();
    test_mid_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
